// File: rtl/mem_to_reg_pipe_if.sv
// mem_to_reg_pipe_if: source/select handshake and registered result bus; sel_err exists only with MTR_SEL_ERR_EN
interface mem_to_reg_pipe_if #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 9,
  parameter int SEL_W  = 4
);
  logic [N_SRC*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
`ifdef MTR_SEL_ERR_EN
  logic                    sel_err;
  modport master (output in_data, sel, in_valid, flush, out_ready,
                  input in_ready, out_data, out_valid, sel_err);
  modport slave  (input in_data, sel, in_valid, flush, out_ready,
                  output in_ready, out_data, out_valid, sel_err);
`else
  modport master (output in_data, sel, in_valid, flush, out_ready,
                  input in_ready, out_data, out_valid);
  modport slave  (input in_data, sel, in_valid, flush, out_ready,
                  output in_ready, out_data, out_valid);
`endif
endinterface

// File: rtl/mem_to_reg_pipe.sv
// mem_to_reg_pipe: registered write-back source selector with valid/ready output; MTR_SEL_ERR_EN adds sticky sel_err
module mem_to_reg_pipe #(
  parameter int DATA_W  = 32,
  parameter int N_SRC   = 9,
  parameter int SEL_W   = 4,
  parameter int K0_CODE = 4,
  parameter int K0_VAL  = 227,
  parameter int K1_CODE = 5,
  parameter int K1_VAL  = 0,
  parameter int K2_CODE = 6,
  parameter int K2_VAL  = 1
) (
  input logic clk,
  input logic reset,
  mem_to_reg_pipe_if.slave bus
);
  logic [DATA_W-1:0] src [N_SRC];
  logic [DATA_W-1:0] dec;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              illegal;
  logic              accept;
  int                s;
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src[i] = bus.in_data[i*DATA_W +: DATA_W];
  end
  // constant codes win over the data slice sharing the same index
  always_comb begin
    s = int'(bus.sel);
    illegal = s != K0_CODE && s != K1_CODE && s != K2_CODE && s >= N_SRC;
    dec = s == K0_CODE ? DATA_W'(K0_VAL) :
          s == K1_CODE ? DATA_W'(K1_VAL) :
          s == K2_CODE ? DATA_W'(K2_VAL) :
          illegal      ? '0 : src[bus.sel];
  end
  assign bus.in_ready  = !out_valid || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (bus.flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_data  <= dec;
      out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef MTR_SEL_ERR_EN
  logic sel_err;
  assign bus.sel_err = sel_err;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sel_err <= 1'b0;
    else if (!bus.flush && accept && illegal) sel_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_mem_to_reg_pipe.sv
// tb_mem_to_reg_pipe: directed checks of decode, handshake, flush and async reset
module tb_mem_to_reg_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  mem_to_reg_pipe_if #(.DATA_W(32), .N_SRC(9), .SEL_W(4)) bus ();
  mem_to_reg_pipe dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 9; i++) bus.in_data[i*32 +: 32] = v;
  endtask
  task automatic put(input int i, input logic [31:0] v);
    bus.in_data[i*32 +: 32] = v;
  endtask
  task automatic chk_err(input string tag, input logic expv);
`ifdef MTR_SEL_ERR_EN
    chk(tag, {31'd0, bus.sel_err}, {31'd0, expv});
`else
    if (expv === 1'bx) $display("unused %s", tag);
`endif
  endtask
  initial begin
    bus.in_data = '0;
    bus.sel = '0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk_err("rst_sel_err", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    put(0, 32'hDEADBEEF);
    bus.sel = 4'd0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("s0_data", bus.out_data, 32'hDEADBEEF);
    chk("s0_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("s0_in_ready", {31'd0, bus.in_ready}, 32'd1);
    fill(32'hFFFFFFFF);
    bus.sel = 4'd4;
    tick();
    chk("k0", bus.out_data, 32'd227);
    bus.sel = 4'd5;
    tick();
    chk("k1", bus.out_data, 32'd0);
    chk("k1_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.sel = 4'd6;
    tick();
    chk("k2", bus.out_data, 32'd1);
    fill(32'd0);
    put(2, 32'hA5A5_0002);
    put(7, 32'h12345678);
    put(8, 32'hCAFEF00D);
    bus.sel = 4'd2;
    tick();
    chk("s2", bus.out_data, 32'hA5A5_0002);
    bus.sel = 4'd7;
    tick();
    chk("s7", bus.out_data, 32'h12345678);
    bus.out_ready = 1'b0;
    bus.sel = 4'd8;
    #1;
    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("stall_data1", bus.out_data, 32'h12345678);
    chk("stall_valid1", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("stall_data2", bus.out_data, 32'h12345678);
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("s8", bus.out_data, 32'hCAFEF00D);
    chk("s8_valid", {31'd0, bus.out_valid}, 32'd1);
    put(1, 32'h0000_1111);
    bus.sel = 4'd1;
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_data", bus.out_data, 32'hCAFEF00D);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("flush_none", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b1;
    bus.sel = 4'd1;
    tick();
    chk("s1", bus.out_data, 32'h0000_1111);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_data", bus.out_data, 32'h0000_1111);
    chk_err("err_before", 1'b0);
    fill(32'h5555AAAA);
    bus.in_valid = 1'b1;
    bus.sel = 4'd9;
    tick();
    chk("ill9_data", bus.out_data, 32'd0);
    chk("ill9_valid", {31'd0, bus.out_valid}, 32'd1);
    chk_err("err_9", 1'b1);
    bus.sel = 4'd3;
    tick();
    chk("s3", bus.out_data, 32'h5555AAAA);
    bus.sel = 4'd15;
    tick();
    chk("ill15_data", bus.out_data, 32'd0);
    chk("ill15_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.sel = 4'd0;
    tick();
    chk("legal_after", bus.out_data, 32'h5555AAAA);
    chk_err("err_sticky", 1'b1);
    bus.flush = 1'b1;
    tick();
    chk("flush2_valid", {31'd0, bus.out_valid}, 32'd0);
    chk_err("err_flush", 1'b1);
    bus.flush = 1'b0;
    bus.sel = 4'd2;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pre_rst_data", bus.out_data, 32'h5555AAAA);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_data", bus.out_data, 32'd0);
    chk_err("async_err", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_to_reg_pipe.md
Name: mem_to_reg_pipe

Overview:
- Parametrised, registered successor to the write-back source selector in the multicycle datapath.
- Selects one of N_SRC data words or one of three built-in constants by select code.
- Captures the result in a one-entry output register with a valid/ready handshake, so the write-back path can stall without losing data.
- Sits between the memory/ALU/shift result buses and the register-file write port.

Parameters:
DATA_W, 32, width of each data word
N_SRC, 9, number of select codes decoded (codes 0..N_SRC-1 legal)
SEL_W, 4, select width; must satisfy 2**SEL_W >= N_SRC
K0_CODE, 4, select code that returns constant K0_VAL
K0_VAL, 227, constant 0 value
K1_CODE, 5, select code that returns constant K1_VAL
K1_VAL, 0, constant 1 value
K2_CODE, 6, select code that returns constant K2_VAL
K2_VAL, 1, constant 2 value

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  N_SRC*DATA_W  packed sources; source i occupies bits [i*DATA_W +: DATA_W]
sel  input  SEL_W  select code
in_valid  input  1  sel/in_data valid this cycle
in_ready  output  1  block can accept this cycle
flush  input  1  synchronous discard of held output
out_data  output  DATA_W  registered selected word
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
sel_err  output  1  sticky illegal-select flag (only with MTR_SEL_ERR_EN)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Reset values: out_data=0, out_valid=0, sel_err=0.
  - in_ready is 1 during and after reset (combinational; see below).
- Decode (combinational, priority order):
  - sel==K0_CODE -> K0_VAL.
  - else sel==K1_CODE -> K1_VAL.
  - else sel==K2_CODE -> K2_VAL.
  - else sel<N_SRC -> in_data slice sel.
  - else illegal -> 0.
  - Constants are zero-extended or truncated to DATA_W.
  - A constant code overrides the data slice of the same index (slices 4..6 are ignored at defaults).
- in_ready = !out_valid || out_ready (combinational; no combinational path from in_valid).
- accept = in_valid && in_ready.
- Per rising edge, priority order:
  - flush=1: out_valid<=0. Any accept in the same cycle is discarded. out_data is unchanged. in_ready may still read 1.
  - else accept: out_data<=decoded word, out_valid<=1. Latency one cycle: the word is visible on the edge after acceptance.
  - else out_valid && out_ready: out_valid<=0, out_data holds its last value.
  - else: hold.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): the old word transfers and the new word loads on the same edge. Full throughput is one word per cycle.
- Stall (out_valid=1, out_ready=0): out_data and out_valid are held stable, in_ready=0, and inputs are ignored.
- An illegal select is still accepted and produces out_data=0 with out_valid=1; the handshake never blocks.
- Reset asserted mid-transfer: the held word is discarded immediately (asynchronous). No output is produced after release until a new accept.

Optional Feature:
- Macro MTR_SEL_ERR_EN.
- Defined:
  - The sel_err port exists.
  - sel_err<=1 on any accepted illegal sel (code >= N_SRC and not a constant code).
  - sel_err is sticky; only reset clears it. flush does not clear it.
  - An accept discarded by flush does not set it.
- Undefined: no sel_err port, no flag logic; illegal selects silently yield 0.

Test Plan:
- Reset low, then release; sel=0, in_data slice0=0xDEADBEEF, in_valid=1, out_ready=1 -> next edge out_data=0xDEADBEEF, out_valid=1, in_ready stays 1.
- Constants: sel=4, 5, 6 on consecutive cycles, all slices=0xFFFFFFFF -> out_data=227, 0, 1 on successive edges, no bubbles.
- Back-pressure: out_ready=0 after loading sel=7 (slice7=0x12345678), then present sel=8 -> out_data holds 0x12345678, in_ready=0. Raise out_ready -> sel=8 word (slice8) loads one edge later.
- Flush with in_valid=1, sel=1 the same cycle -> out_valid=0 next edge, out_data unchanged, no word delivered.
- Illegal sel=15 accepted -> out_data=0, out_valid=1. With MTR_SEL_ERR_EN, sel_err=1 and it stays 1 across a later legal transfer and a flush until reset.
- Assert reset while out_valid=1, out_ready=0 -> out_valid and out_data drop to 0 immediately, before the next clock edge.
